instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared RV32 core types and constants used by the instruction fetch stage.
package instr_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with flush; head entry is read straight from storage.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// RV32 instruction fetch: PC, credit-limited imem requests, response buffer, redirect flush.
// Optional misaligned-redirect fault/halt enabled by FETCH_MISALIGN_CHECK_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned INF_W = CNT_W + 1;
  localparam int unsigned ENT_W = $bits(fetch_entry_t);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic            r_fault;
  logic            w_fault_nxt;
  logic [XLEN-1:0] r_pc;
  logic [INF_W-1:0] r_drop;

  logic [CNT_W-1:0] w_out;
  logic [CNT_W-1:0] w_occ;
  logic             w_pc_empty;
  logic             w_buf_empty;
  logic [XLEN-1:0]  w_pc_head;
  fetch_entry_t     w_buf_head;
  fetch_entry_t     w_buf_wdata;
  logic             w_pop;
  logic             w_rsp_live;
  logic             w_credit;
  logic             w_inflight_ok;
  logic             w_halted;
  logic             w_req_hs;

  assign w_halted   = (r_state == ST_HALT);
  assign w_pop      = !w_buf_empty && instr_ready;
  assign w_rsp_live = imem_rsp_valid && (r_drop == '0) && !w_pc_empty;

  // A slot freed by this cycle's decode pop can be reused by this cycle's request.
  assign w_credit = (INF_W'(w_out) + INF_W'(w_occ) - INF_W'(w_pop)) < INF_W'(BUF_DEPTH);
  // Bounds live plus stale in-flight so back-to-back redirects cannot overflow r_drop.
  assign w_inflight_ok = (INF_W'(w_out) + r_drop) < INF_W'(2 * BUF_DEPTH);

  assign imem_req_valid = reset && !redirect_valid && !w_halted && w_credit && w_inflight_ok;
  assign imem_req_addr  = r_pc;
  assign w_req_hs       = imem_req_valid && imem_req_ready;

  assign w_buf_wdata = '{instr: imem_rsp_data, pc: w_pc_head};

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_pc_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_req_hs),
    .i_data  (r_pc),
    .i_pop   (w_rsp_live),
    .o_data  (w_pc_head),
    .o_empty (w_pc_empty),
    .o_count (w_out)
  );

  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(BUF_DEPTH)) u_buf_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_rsp_live),
    .i_data  (w_buf_wdata),
    .i_pop   (w_pop),
    .o_data  (w_buf_head),
    .o_empty (w_buf_empty),
    .o_count (w_occ)
  );

  assign instr_valid = !w_buf_empty;
  assign instr       = w_buf_head.instr;
  assign instr_pc    = w_buf_head.pc;
  assign fetch_fault = r_fault;

  // On redirect every request still in flight becomes a response to discard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_drop <= '0;
    end else if (redirect_valid) begin
      r_pc   <= redirect_pc & ~XLEN'(WORD_BYTES - 1);
      r_drop <= INF_W'(w_out) + r_drop - INF_W'(imem_rsp_valid);
    end else begin
      if (w_req_hs) begin
        r_pc <= r_pc + XLEN'(WORD_BYTES);
      end
      if (imem_rsp_valid && (r_drop != '0)) begin
        r_drop <= r_drop - INF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fault_nxt = r_fault;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        w_state_nxt = ST_HALT;
        w_fault_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_RUN;
        w_fault_nxt = 1'b0;
      end
    end
`else
    w_state_nxt = ST_RUN;
    w_fault_nxt = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order memory model plus expected-PC scoreboard.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  int          n_tests;
  int          n_fail;
  int          cycle;
  int          mem_lat;
  int          first_valid;
  int          n_deliv;
  int          n_req;
  logic [31:0] model_pc;
  logic        model_halted;
  logic        want_first;
  logic [31:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample just after the falling edge, score, advance.
  task automatic step();
    logic [31:0] e;
    mem_t        m;
    if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      mem_q.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (instr_valid && first_valid < 0) first_valid = cycle;
    if (model_halted) begin
      check("halt_no_req", {31'h0, imem_req_valid}, 32'h0);
      check("halt_no_instr", {31'h0, instr_valid}, 32'h0);
    end
    if (instr_valid && instr_ready) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 32'hDEAD_BEEF;
      check("instr_pc", instr_pc, e);
      check("instr_data", instr, mem_word(e));
      if (want_first) begin
        first_pc   = instr_pc;
        want_first = 1'b0;
      end
      n_deliv++;
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, model_pc);
      exp_q.push_back(model_pc);
      m.addr = imem_req_addr;
      m.due  = cycle + mem_lat;
      mem_q.push_back(m);
      model_pc = model_pc + 32'd4;
      n_req++;
    end
    if (redirect_valid) begin
      check("redir_no_req", {31'h0, imem_req_valid}, 32'h0);
      exp_q.delete();
      model_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
      model_halted = (redirect_pc[1:0] != 2'b00);
`endif
    end
    @(negedge clk);
    cycle++;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    mem_q.delete();
    exp_q.delete();
    model_pc     = 32'h0;
    model_halted = 1'b0;
    want_first   = 1'b0;
    first_valid  = -1;
    n_deliv      = 0;
    n_req        = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fault", {31'h0, fetch_fault}, 32'h0);
    reset = 1'b1;
    cycle = 1;
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    check("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    mem_lat        = 1;
    cycle          = 0;

    // Streaming with 1-cycle memory.
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (12) step();
    check("first_valid_cycle", 32'(first_valid), 32'd3);
    check("throughput", 32'(n_deliv), 32'd10);
    drain();

    // Decode stalled: only BUF_DEPTH requests go out.
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    repeat (10) step();
    #1;
    check("stall_req_count", 32'(n_req), 32'd2);
    check("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("stall_instr_valid", {31'h0, instr_valid}, 32'h1);
    drain();
    check("stall_deliv_count", 32'(n_deliv), 32'd2);

    // Memory not ready: request held stable.
    do_reset();
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    repeat (5) begin
      #1;
      check("hold_valid", {31'h0, imem_req_valid}, 32'h1);
      check("hold_addr", imem_req_addr, 32'h0);
      check("hold_no_instr", {31'h0, instr_valid}, 32'h0);
      step();
    end
    imem_req_ready = 1'b1;
    repeat (8) step();
    drain();

    // 3-cycle memory, redirect with two requests in flight.
    do_reset();
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    #1;
    check("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("redir_req_addr", imem_req_addr, 32'h0000_0100);
    check("redir_instr_low", {31'h0, instr_valid}, 32'h0);
    want_first = 1'b1;
    repeat (12) step();
    check("redir_first_pc", first_pc, 32'h0000_0100);
    drain();

    // Redirect colliding with a decode handshake and a response.
    do_reset();
    mem_lat        = 1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (6) step();
    d0             = n_deliv;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    #1;
    check("coll_pop_taken", 32'(n_deliv), 32'(d0 + 1));
    check("coll_buf_empty", {31'h0, instr_valid}, 32'h0);
    check("coll_req_addr", imem_req_addr, 32'h0000_0300);
    want_first = 1'b1;
    repeat (6) step();
    check("coll_first_pc", first_pc, 32'h0000_0300);
    drain();

    // Misaligned redirect.
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (3) step();
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    #1;
    check("mis_fault_set", {31'h0, fetch_fault}, 32'h1);
    check("mis_no_req", {31'h0, imem_req_valid}, 32'h0);
    repeat (4) step();
    #1;
    check("mis_fault_sticky", {31'h0, fetch_fault}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    #1;
    check("mis_fault_clear", {31'h0, fetch_fault}, 32'h0);
    check("mis_resume_valid", {31'h0, imem_req_valid}, 32'h1);
    check("mis_resume_addr", imem_req_addr, 32'h0000_0200);
    want_first = 1'b1;
    repeat (8) step();
    check("mis_first_pc", first_pc, 32'h0000_0200);
`else
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0402;
    step();
    #1;
    check("mis_aligned_addr", imem_req_addr, 32'h0000_0400);
    check("mis_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("mis_no_fault", {31'h0, fetch_fault}, 32'h0);
    want_first = 1'b1;
    repeat (6) step();
    check("mis_first_pc", first_pc, 32'h0000_0400);
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
